tx_scheduler: RTL and testbench

TX_SCHEDULER -- requirements
Module: tx_scheduler

---
 rtl/tx_scheduler.sv | 108 ++++++++++
 tb/tb_tx_scheduler.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/tx_scheduler.sv
// Link-layer transmit scheduler: trains the serial link with COM characters, then
// arbitrates two byte requesters onto one output with round-robin priority.
module tx_scheduler #(
    parameter int          TRAIN_LEN = 4,
    parameter logic [7:0]  COM       = 8'hBC
) (
    input  logic       clk_4f,
    input  logic       reset,
    input  logic       enable,
    input  logic [7:0] data0,
    input  logic       valid0,
    output logic       ready0,
    input  logic [7:0] data1,
    input  logic       valid1,
    output logic       ready1,
    output logic [7:0] data_out,
    output logic       valid_out,
    output logic       link_up
);

    localparam int CNT_W = (TRAIN_LEN > 1) ? $clog2(TRAIN_LEN) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        TRAIN  = 2'd1,
        ACTIVE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             prio_q, prio_d;
    logic             grant0, grant1;
    logic             can_send;
    logic [7:0]       data_p1;
    logic             vld_p1;

    // Next-state, training count and arbitration
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        prio_d   = prio_q;
        can_send = 1'b0;
        grant0   = 1'b0;
        grant1   = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (enable) state_d = TRAIN;
            end
            TRAIN: begin
                if (cnt_q == CNT_W'(TRAIN_LEN - 1)) begin
                    state_d = ACTIVE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ACTIVE: begin
                cnt_d = '0;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        // Dropping enable aborts training or traffic unconditionally
        if (!enable) begin
            state_d = IDLE;
            cnt_d   = '0;
        end

        // Reset gates grants so nothing is consumed on the aborting edge
        can_send = (state_q == ACTIVE) && enable && !reset;
        grant0   = can_send && valid0 && (!valid1 || !prio_q);
        grant1   = can_send && valid1 && (!valid0 ||  prio_q);

        if (grant0)      prio_d = 1'b1;
        else if (grant1) prio_d = 1'b0;
    end

    // Stage p1: state and registered output byte
    always_ff @(posedge clk_4f) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            prio_q  <= 1'b0;
            data_p1 <= COM;
            vld_p1  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            prio_q  <= prio_d;
            vld_p1  <= grant0 || grant1;
            if (grant0)      data_p1 <= data0;
            else if (grant1) data_p1 <= data1;
            else             data_p1 <= COM;
        end
    end

    assign ready0    = grant0;
    assign ready1    = grant1;
    assign data_out  = data_p1;
    assign valid_out = vld_p1;
    assign link_up   = (state_q == ACTIVE);

endmodule

// File: tb/tb_tx_scheduler.sv
// Directed bench for tx_scheduler: ready checked combinationally each cycle,
// expected output bytes queued at drive time and compared one edge later.
module tb_tx_scheduler;

    localparam logic [7:0] COM = 8'hBC;

    logic       clk_4f = 1'b0;
    logic       reset;
    logic       enable;
    logic [7:0] data0, data1;
    logic       valid0, valid1;
    logic       ready0, ready1;
    logic [7:0] data_out;
    logic       valid_out;
    logic       link_up;

    int vectors = 0;
    int errs    = 0;
    logic [8:0] exp_q[$];

    tx_scheduler #(.TRAIN_LEN(4), .COM(8'hBC)) dut (
        .clk_4f   (clk_4f),
        .reset    (reset),
        .enable   (enable),
        .data0    (data0),
        .valid0   (valid0),
        .ready0   (ready0),
        .data1    (data1),
        .valid1   (valid1),
        .ready1   (ready1),
        .data_out (data_out),
        .valid_out(valid_out),
        .link_up  (link_up)
    );

    always #5 clk_4f = ~clk_4f;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    task automatic check1(input string tag, input logic obs, input logic expv);
        vectors++;
        assert (obs === expv) else begin
            errs++;
            $error("FAIL %s: got %b, required %b", tag, obs, expv);
        end
    endtask

    // One clock cycle: drive, check ready, queue the expected output, check it after the edge
    task automatic step(input string tag, input logic rst, input logic en,
                        input logic v0, input logic [7:0] d0,
                        input logic v1, input logic [7:0] d1,
                        input logic exp_r0, input logic exp_r1, input logic exp_link);
        logic [8:0] expv;
        logic [8:0] got;
        @(negedge clk_4f);
        reset  = rst;
        enable = en;
        valid0 = v0;
        data0  = d0;
        valid1 = v1;
        data1  = d1;
        #1;
        check1({tag, ".ready0"}, ready0, exp_r0);
        check1({tag, ".ready1"}, ready1, exp_r1);
        if (exp_r0)      exp_q.push_back({1'b1, d0});
        else if (exp_r1) exp_q.push_back({1'b1, d1});
        else             exp_q.push_back({1'b0, COM});
        @(posedge clk_4f);
        #1;
        vectors++;
        assert (exp_q.size() > 0) else begin
            errs++;
            $error("FAIL %s.queue: got empty scoreboard, required an entry", tag);
        end
        if (exp_q.size() > 0) begin
            expv = exp_q.pop_front();
            got  = {valid_out, data_out};
            vectors++;
            assert (got === expv) else begin
                errs++;
                $error("FAIL %s.out: got valid=%b data=%h, required valid=%b data=%h",
                       tag, got[8], got[7:0], expv[8], expv[7:0]);
            end
        end
        check1({tag, ".link_up"}, link_up, exp_link);
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0;
        valid0 = 1'b0; valid1 = 1'b0; data0 = 8'h00; data1 = 8'h00;

        // Reset state, valid inputs must be ignored
        step("rst0", 1, 0, 0, 8'h00, 0, 8'h00, 0, 0, 0);
        step("rst1", 1, 1, 1, 8'h55, 1, 8'h66, 0, 0, 0);

        // Release with enable: one IDLE cycle then four TRAIN cycles, ACTIVE on the fifth edge
        step("idle",  0, 1, 0, 8'h00, 0, 8'h00, 0, 0, 0);
        step("trn0",  0, 1, 1, 8'h77, 0, 8'h00, 0, 0, 0);
        step("trn1",  0, 1, 1, 8'h77, 1, 8'h88, 0, 0, 0);
        step("trn2",  0, 1, 0, 8'h00, 1, 8'h88, 0, 0, 0);
        step("trn3",  0, 1, 0, 8'h00, 0, 8'h00, 0, 0, 1);

        // Single requester 0 transfer (prio -> 1), then requester 1 only (prio -> 0)
        step("r0_AA", 0, 1, 1, 8'hAA, 0, 8'h00, 1, 0, 1);
        step("r1_11", 0, 1, 0, 8'h00, 1, 8'h11, 0, 1, 1);

        // Both valid, alternating grants: AA, CC, BB, DD
        step("alt0",  0, 1, 1, 8'hAA, 1, 8'hCC, 1, 0, 1);
        step("alt1",  0, 1, 1, 8'hBB, 1, 8'hCC, 0, 1, 1);
        step("alt2",  0, 1, 1, 8'hBB, 1, 8'hDD, 1, 0, 1);
        step("alt3",  0, 1, 0, 8'h00, 1, 8'hDD, 0, 1, 1);

        // Idle cycles leave prio alone
        step("nop0",  0, 1, 0, 8'h00, 0, 8'h00, 0, 0, 1);
        step("prio0", 0, 1, 1, 8'h12, 1, 8'h34, 1, 0, 1);
        step("nop1",  0, 1, 0, 8'h00, 0, 8'h00, 0, 0, 1);
        step("prio1", 0, 1, 1, 8'h56, 1, 8'h78, 0, 1, 1);

        // Enable dropped in ACTIVE: no grant, IDLE next
        step("dis",   0, 0, 1, 8'h9A, 1, 8'h9B, 0, 0, 0);

        // Re-enable, abort training at count 2, then full training again
        step("re_id", 0, 1, 0, 8'h00, 0, 8'h00, 0, 0, 0);
        step("ab_c0", 0, 1, 0, 8'h00, 0, 8'h00, 0, 0, 0);
        step("ab_c1", 0, 1, 0, 8'h00, 0, 8'h00, 0, 0, 0);
        step("ab_c2", 0, 0, 0, 8'h00, 0, 8'h00, 0, 0, 0);
        step("rt_id", 0, 1, 0, 8'h00, 0, 8'h00, 0, 0, 0);
        step("rt_c0", 0, 1, 0, 8'h00, 0, 8'h00, 0, 0, 0);
        step("rt_c1", 0, 1, 0, 8'h00, 0, 8'h00, 0, 0, 0);
        step("rt_c2", 0, 1, 0, 8'h00, 0, 8'h00, 0, 0, 0);
        step("rt_c3", 0, 1, 0, 8'h00, 0, 8'h00, 0, 0, 1);

        // Reset during an ACTIVE transfer of DD: nothing emitted
        step("pre_dd", 0, 1, 1, 8'hEE, 0, 8'h00, 1, 0, 1);
        step("rst_dd", 1, 1, 1, 8'hDD, 0, 8'h00, 0, 0, 0);
        step("rst_hold", 1, 1, 1, 8'hDD, 1, 8'h44, 0, 0, 0);
        step("post", 0, 1, 1, 8'hDD, 0, 8'h00, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
